uart_rx_data_sampler: RTL and testbench
=======================================

// Module: uart_rx_data_sampler
// PURPOSE
//  - UART RX front-end stage, upstream of the parity check, start/stop check and deserializer.
//  - Synchronizes the raw RX line and runs an oversampling edge counter per bit period.
//  - Takes a majority vote of the mid-bit samples and issues one sampled_bit plus a valid strobe per bit.
//  - The RX FSM consumes sampled_bit, the valid strobe and bit_done; the parity checker reads sampled_bit.
// PARAMETERS
//  - PRESCALE_WIDTH  6  width of prescale input and edge counter
// PORTS
//  CLK_DATA_SAMP          in   1   system clock (oversampling clock)
//  RST_DATA_SAMP          in   1   asynchronous reset, active-low
//  RX_IN_DATA_SAMP        in   1   raw serial line, asynchronous to the clock
//  Prescale_DATA_SAMP     in   6   oversampling ratio; legal values 8, 16, 32
//  dat_samp_en_DATA_SAMP  in   1   enable from the RX FSM; high while a frame is being received
//  sampled_bit_DATA_SAMP  out  1   majority-voted bit value
//  samp_valid_DATA_SAMP   out  1   1-cycle pulse: sampled_bit updated this cycle
//  edge_cnt_DATA_SAMP     out  6   current edge index within the bit, 0..prescale-1
//  bit_done_DATA_SAMP     out  1   1-cycle pulse on the last edge of each bit (edge_cnt == prescale-1)
//  rx_sync_DATA_SAMP      out  1   synchronized line; the FSM uses it for start-bit detection
// BEHAVIOUR
//  - Synchronizer: 2-FF on RX_IN; both flops reset to 1 (idle). Line-to-rx_sync latency is 2 clocks.
//  - Effective prescale P: Prescale_DATA_SAMP if it is 8, 16 or 32; any other value is treated as 8.
//    - P is latched into an internal register on the enable rising cycle and at every bit wrap.
//    - A change to Prescale mid-bit has no effect until the next bit.
//  - Edge counter:
//    - Held at 0 while enable is low.
//    - While enable is high it increments each clock. At P-1 it wraps to 0 and bit_done pulses the same cycle.
//  - Vote points: M = P/2; samples of rx_sync are captured at edge_cnt = M-1, M and M+1 (3-vote).
//  - The cycle after the edge_cnt = M+1 capture:
//    - sampled_bit <= majority(s0, s1, s2) and samp_valid = 1 for exactly that cycle.
//    - Latency from the last vote edge to valid is 1 clock.
//  - sampled_bit holds its value between bits and while disabled; it is never forced while enabled.
//  - Enable falling mid-bit:
//    - edge_cnt and the vote registers clear on the next clock.
//    - No samp_valid or bit_done is generated for the partial bit.
//  - Enable re-asserted: counting restarts from edge 0 on the next clock (new bit alignment).
//  - Enable dropping on the same cycle as a pending valid: the valid still fires (it is already registered).
//  - Reset (asynchronous, any time, including mid-bit): sampled_bit=1, samp_valid=0, edge_cnt=0,
//    bit_done=0, rx_sync=1, vote regs=1, latched P=8.
//  - Implementation is registered outputs only; no combinational path from RX_IN to any output.
// CONFIGURATION
//  - Macro DATA_SAMP_FIVE_VOTE_EN.
//  - Defined: 5 samples at edge_cnt = M-2..M+2 are majority-voted (3 of 5); samp_valid fires the cycle after M+2.
//  - Undefined (default): 3-vote at M-1..M+1 as above.
//  - Ports and all other timing are identical in both builds.
// TESTING
//  - Reset: assert RST low mid-bit, P=16 -> all outputs at reset values in the same cycle; rx_sync=1.
//  - P=8, line 0 (stable before the sync delay), enable high:
//    - samples at edges 3, 4, 5; valid pulse with sampled_bit=0 at the cycle after edge 5.
//    - bit_done at edge 7; edge_cnt then reads 0.
//  - Glitch reject, P=16, line 1 with a 1-clock 0 at the sync output on edge 8 -> sampled_bit=1, one valid per bit.
//  - Disable at edge 5 (P=8) -> edge_cnt=0 next clock, no valid or bit_done; re-enable -> edge 0 and a fresh bit.
//  - Prescale=20 -> behaves exactly as P=8; change Prescale 8->16 at edge 2 -> the current bit still uses 8.
//  - DATA_SAMP_FIVE_VOTE_EN, P=16, zeros on edges 6 and 7 only -> sampled_bit=1, valid the cycle after edge 10.

Source files
------------

// File: rtl/uart_rx_data_sampler.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_data_sampler
// Description : UART RX front end. It synchronises the line, counts oversampling
//               edges per bit and majority-votes the mid-bit samples.
//               DATA_SAMP_FIVE_VOTE_EN selects a 5-sample vote (3-sample otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_data_sampler #(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK_DATA_SAMP,
    input  logic                      RST_DATA_SAMP,
    input  logic                      RX_IN_DATA_SAMP,
    input  logic [PRESCALE_WIDTH-1:0] Prescale_DATA_SAMP,
    input  logic                      dat_samp_en_DATA_SAMP,
    output logic                      sampled_bit_DATA_SAMP,
    output logic                      samp_valid_DATA_SAMP,
    output logic [PRESCALE_WIDTH-1:0] edge_cnt_DATA_SAMP,
    output logic                      bit_done_DATA_SAMP,
    output logic                      rx_sync_DATA_SAMP
);

`ifdef DATA_SAMP_FIVE_VOTE_EN
    localparam int NUM_VOTES = 5;
`else
    localparam int NUM_VOTES = 3;
`endif
    localparam int VOTE_OFS = NUM_VOTES / 2;

    localparam logic [PRESCALE_WIDTH-1:0] C_P8  = PRESCALE_WIDTH'(8);
    localparam logic [PRESCALE_WIDTH-1:0] C_P16 = PRESCALE_WIDTH'(16);
    localparam logic [PRESCALE_WIDTH-1:0] C_P32 = PRESCALE_WIDTH'(32);
    localparam logic [PRESCALE_WIDTH-1:0] C_ONE = PRESCALE_WIDTH'(1);

    logic                      r_sync1;
    logic                      r_sync2;
    logic                      r_en_d;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic [PRESCALE_WIDTH-1:0] r_cnt;
    logic                      r_bit_done;
    logic                      r_valid;
    logic                      r_sampled;
    logic [NUM_VOTES-2:0]      r_votes;

    logic                      w_en;
    logic [PRESCALE_WIDTH-1:0] w_p_eff;
    logic                      w_wrap;
    logic                      w_latch_p;
    logic [PRESCALE_WIDTH-1:0] w_p_nxt;
    logic [PRESCALE_WIDTH-1:0] w_cnt_nxt;
    logic                      w_done_nxt;
    logic [PRESCALE_WIDTH-1:0] w_vote_lo;
    logic [PRESCALE_WIDTH-1:0] w_vote_idx;
    logic                      w_last_vote;
    logic [2:0]                w_ones;
    logic                      w_majority;

    assign w_en = dat_samp_en_DATA_SAMP;

    // Unsupported ratios fall back to 8x oversampling.
    always_comb begin
        w_p_eff = C_P8;
        if (Prescale_DATA_SAMP == C_P16 || Prescale_DATA_SAMP == C_P32) begin
            w_p_eff = Prescale_DATA_SAMP;
        end
    end

    assign w_wrap    = w_en && (r_cnt == (r_prescale - C_ONE));
    assign w_latch_p = w_en && (!r_en_d || w_wrap);
    assign w_p_nxt   = w_latch_p ? w_p_eff : r_prescale;
    assign w_cnt_nxt = (!w_en || w_wrap) ? '0 : (r_cnt + C_ONE);

    // bit_done is registered so that it lines up with edge_cnt reading P-1.
    assign w_done_nxt = w_en && (w_cnt_nxt == (w_p_nxt - C_ONE));

    assign w_vote_lo   = (r_prescale >> 1) - PRESCALE_WIDTH'(VOTE_OFS);
    assign w_vote_idx  = r_cnt - w_vote_lo;
    assign w_last_vote = w_en && (w_vote_idx == PRESCALE_WIDTH'(NUM_VOTES - 1));

    // The final sample is taken straight from the synchroniser so valid lands one clock later.
    always_comb begin
        w_ones = {2'b00, r_sync2};
        for (int i = 0; i < NUM_VOTES - 1; i++) begin
            w_ones = w_ones + {2'b00, r_votes[i]};
        end
        w_majority = (w_ones > 3'(VOTE_OFS));
    end

    always_ff @(posedge CLK_DATA_SAMP or negedge RST_DATA_SAMP) begin
        if (!RST_DATA_SAMP) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= RX_IN_DATA_SAMP;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge CLK_DATA_SAMP or negedge RST_DATA_SAMP) begin
        if (!RST_DATA_SAMP) begin
            r_en_d     <= 1'b0;
            r_prescale <= C_P8;
            r_cnt      <= '0;
            r_bit_done <= 1'b0;
        end else begin
            r_en_d     <= w_en;
            r_prescale <= w_p_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit_done <= w_done_nxt;
        end
    end

    always_ff @(posedge CLK_DATA_SAMP or negedge RST_DATA_SAMP) begin
        if (!RST_DATA_SAMP) begin
            r_votes   <= '1;
            r_valid   <= 1'b0;
            r_sampled <= 1'b1;
        end else begin
            r_valid <= w_last_vote;
            if (w_last_vote) begin
                r_sampled <= w_majority;
            end
            if (!w_en) begin
                r_votes <= '1;
            end else begin
                for (int i = 0; i < NUM_VOTES - 1; i++) begin
                    if (w_vote_idx == PRESCALE_WIDTH'(i)) begin
                        r_votes[i] <= r_sync2;
                    end
                end
            end
        end
    end

    assign sampled_bit_DATA_SAMP = r_sampled;
    assign samp_valid_DATA_SAMP  = r_valid;
    assign edge_cnt_DATA_SAMP    = r_cnt;
    assign bit_done_DATA_SAMP    = r_bit_done;
    assign rx_sync_DATA_SAMP     = r_sync2;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_data_sampler.sv
`default_nettype none
// tb_uart_rx_data_sampler: directed and randomized checks of the data sampler
// against a bit-schedule reference model built from line/enable history.
module tb_uart_rx_data_sampler;

`ifdef DATA_SAMP_FIVE_VOTE_EN
    localparam int OFS = 2;
`else
    localparam int OFS = 1;
`endif
    localparam int MAXC = 8192;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_in = 1'b1;
    logic       en    = 1'b0;
    logic [5:0] presc = 6'd8;
    logic       sbit;
    logic       svalid;
    logic       bdone;
    logic       rsync;
    logic [5:0] ecnt;

    uart_rx_data_sampler #(.PRESCALE_WIDTH(6)) dut (
        .CLK_DATA_SAMP         (clk),
        .RST_DATA_SAMP         (rst_n),
        .RX_IN_DATA_SAMP       (rx_in),
        .Prescale_DATA_SAMP    (presc),
        .dat_samp_en_DATA_SAMP (en),
        .sampled_bit_DATA_SAMP (sbit),
        .samp_valid_DATA_SAMP  (svalid),
        .edge_cnt_DATA_SAMP    (ecnt),
        .bit_done_DATA_SAMP    (bdone),
        .rx_sync_DATA_SAMP     (rsync)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    bit line_h [MAXC];
    bit en_h   [MAXC];
    int m_start  = 0;
    int m_P      = 8;
    int prev_cnt = 0;
    int prev_P   = 8;
    int exp_cnt  = 0;
    bit exp_done  = 1'b0;
    bit exp_valid = 1'b0;
    bit exp_sync  = 1'b1;
    bit exp_sbit  = 1'b1;

    function automatic int peff(input logic [5:0] p);
        return (p == 6'd8 || p == 6'd16 || p == 6'd32) ? int'(p) : 8;
    endfunction

    function automatic bit line_at(input int k);
        return (k < 0) ? 1'b1 : line_h[k];
    endfunction

    // Drive one clock of stimulus and predict this cycle's outputs from history.
    task automatic cycle(input bit line, input bit e, input logic [5:0] p);
        bit enp;
        int ones;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        @(posedge clk);
        #1;
        rx_in = line;
        en    = e;
        presc = p;
        line_h[cyc] = line;
        en_h[cyc]   = e;
        enp       = (cyc > 0) ? en_h[cyc-1] : 1'b0;
        exp_cnt   = enp ? (cyc - m_start) : 0;
        exp_done  = enp && (exp_cnt == m_P - 1);
        exp_valid = enp && (prev_cnt == prev_P / 2 + OFS);
        if (exp_valid) begin
            ones = 0;
            for (int k = 0; k <= 2 * OFS; k++) ones += int'(line_at(cyc - 3 - k));
            exp_sbit = (ones > OFS);
        end
        exp_sync = line_at(cyc - 2);
        prev_cnt = exp_cnt;
        prev_P   = m_P;
        if (e && !enp) begin
            m_start = cyc;
            m_P     = peff(p);
        end else if (e && (exp_cnt == m_P - 1)) begin
            m_start = cyc + 1;
            m_P     = peff(p);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic release_reset();
        rx_in = 1'b1;
        en    = 1'b0;
        presc = 6'd8;
        @(negedge clk);
        rst_n    = 1'b1;
        cyc      = 0;
        m_start  = 0;
        m_P      = 8;
        prev_cnt = 0;
        prev_P   = 8;
        exp_sbit = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        n_total++; if (sbit   !== 1'b1) $display("FAIL reset_sampled_bit got=%b exp=1", sbit);   else n_pass++;
        n_total++; if (svalid !== 1'b0) $display("FAIL reset_samp_valid got=%b exp=0", svalid); else n_pass++;
        n_total++; if (ecnt   !== 6'd0) $display("FAIL reset_edge_cnt got=%0d exp=0", ecnt);   else n_pass++;
        n_total++; if (bdone  !== 1'b0) $display("FAIL reset_bit_done got=%b exp=0", bdone);   else n_pass++;
        n_total++; if (rsync  !== 1'b1) $display("FAIL reset_rx_sync got=%b exp=1", rsync);    else n_pass++;
        release_reset();
    endtask

    task automatic test_p8_basic();
        int  nvalid = 0;
        bit  prev_done = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 6'd8);
        for (int i = 0; i < 17; i++) begin
            cycle(1'b0, 1'b1, 6'd8);
            n_total++; if (ecnt   !== 6'(exp_cnt)) $display("FAIL p8_edge_cnt i=%0d got=%0d exp=%0d", i, ecnt, exp_cnt); else n_pass++;
            n_total++; if (bdone  !== exp_done)    $display("FAIL p8_bit_done i=%0d got=%b exp=%b", i, bdone, exp_done); else n_pass++;
            n_total++; if (svalid !== exp_valid)   $display("FAIL p8_valid i=%0d got=%b exp=%b", i, svalid, exp_valid); else n_pass++;
            n_total++; if (sbit   !== exp_sbit)    $display("FAIL p8_sampled_bit i=%0d got=%b exp=%b", i, sbit, exp_sbit); else n_pass++;
            n_total++; if (rsync  !== exp_sync)    $display("FAIL p8_rx_sync i=%0d got=%b exp=%b", i, rsync, exp_sync); else n_pass++;
            if (svalid === 1'b1) begin
                nvalid++;
                n_total++;
                if (ecnt !== 6'(4 + OFS + 1) || sbit !== 1'b0)
                    $display("FAIL p8_valid_point edge_cnt=%0d bit=%b exp edge_cnt=%0d bit=0", ecnt, sbit, 4 + OFS + 1);
                else n_pass++;
            end
            if (prev_done) begin
                n_total++; if (ecnt !== 6'd0) $display("FAIL p8_after_done edge_cnt=%0d exp=0", ecnt); else n_pass++;
            end
            if (bdone === 1'b1) begin
                n_total++; if (ecnt !== 6'd7) $display("FAIL p8_done_edge edge_cnt=%0d exp=7", ecnt); else n_pass++;
            end
            prev_done = (bdone === 1'b1);
        end
        n_total++; if (nvalid != 2) $display("FAIL p8_valid_count got=%0d exp=2", nvalid); else n_pass++;
    endtask

    task automatic test_glitch();
        int nvalid = 0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 6'd16);
        for (int i = 0; i < 32; i++) begin
            cycle((i == 6) ? 1'b0 : 1'b1, 1'b1, 6'd16);
            n_total++; if (svalid !== exp_valid) $display("FAIL glitch_valid i=%0d got=%b exp=%b", i, svalid, exp_valid); else n_pass++;
            n_total++; if (sbit   !== exp_sbit)  $display("FAIL glitch_sampled_bit i=%0d got=%b exp=%b", i, sbit, exp_sbit); else n_pass++;
            if (svalid === 1'b1) nvalid++;
        end
        n_total++; if (nvalid != 2)    $display("FAIL glitch_valid_count got=%0d exp=2", nvalid); else n_pass++;
        n_total++; if (sbit !== 1'b1)  $display("FAIL glitch_reject got=%b exp=1", sbit); else n_pass++;
    endtask

    task automatic test_disable();
        int partial_pulses = 0;
        int fresh_valid    = 0;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 6'd8);
        for (int i = 0; i < 18; i++) begin
            cycle(1'b0, (i < 5) || (i >= 9), 6'd8);
            n_total++; if (ecnt   !== 6'(exp_cnt)) $display("FAIL dis_edge_cnt i=%0d got=%0d exp=%0d", i, ecnt, exp_cnt); else n_pass++;
            n_total++; if (bdone  !== exp_done)    $display("FAIL dis_bit_done i=%0d got=%b exp=%b", i, bdone, exp_done); else n_pass++;
            n_total++; if (svalid !== exp_valid)   $display("FAIL dis_valid i=%0d got=%b exp=%b", i, svalid, exp_valid); else n_pass++;
            n_total++; if (sbit   !== exp_sbit)    $display("FAIL dis_sampled_bit i=%0d got=%b exp=%b", i, sbit, exp_sbit); else n_pass++;
            if (i < 9 && (svalid === 1'b1 || bdone === 1'b1)) partial_pulses++;
            if (i >= 9 && svalid === 1'b1) fresh_valid++;
            if (i == 6) begin
                n_total++; if (ecnt !== 6'd0) $display("FAIL dis_clear edge_cnt=%0d exp=0", ecnt); else n_pass++;
            end
            if (i == 10) begin
                n_total++; if (ecnt !== 6'd1) $display("FAIL dis_restart edge_cnt=%0d exp=1", ecnt); else n_pass++;
            end
        end
        n_total++; if (partial_pulses != 0) $display("FAIL dis_partial_pulses got=%0d exp=0", partial_pulses); else n_pass++;
        n_total++; if (fresh_valid != 1)    $display("FAIL dis_fresh_valid got=%0d exp=1", fresh_valid); else n_pass++;
        n_total++; if (sbit !== 1'b0)       $display("FAIL dis_fresh_bit got=%b exp=0", sbit); else n_pass++;
    endtask

    task automatic test_prescale();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 6'd20);
        for (int i = 0; i < 24; i++) begin
            cycle(1'b1, 1'b1, 6'd20);
            n_total++; if (ecnt  !== 6'(i % 8))    $display("FAIL p20_edge_cnt i=%0d got=%0d exp=%0d", i, ecnt, i % 8); else n_pass++;
            n_total++; if (bdone !== (i % 8 == 7)) $display("FAIL p20_bit_done i=%0d got=%b exp=%b", i, bdone, (i % 8 == 7)); else n_pass++;
        end
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 6'd8);
        for (int i = 0; i < 26; i++) begin
            cycle(1'b1, 1'b1, (i < 2) ? 6'd8 : 6'd16);
            n_total++; if (ecnt  !== 6'(exp_cnt))         $display("FAIL pchg_edge_cnt i=%0d got=%0d exp=%0d", i, ecnt, exp_cnt); else n_pass++;
            n_total++; if (bdone !== (i == 7 || i == 23)) $display("FAIL pchg_bit_done i=%0d got=%b exp=%b", i, bdone, (i == 7 || i == 23)); else n_pass++;
        end
    endtask

    task automatic test_vote_pattern();
        int vpos = 16 + 8 + OFS + 1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 6'd16);
        for (int i = 0; i < 32; i++) begin
            cycle((i < 16 || i == 20 || i == 21) ? 1'b0 : 1'b1, 1'b1, 6'd16);
            n_total++; if (svalid !== exp_valid) $display("FAIL vote_valid i=%0d got=%b exp=%b", i, svalid, exp_valid); else n_pass++;
            n_total++; if (sbit   !== exp_sbit)  $display("FAIL vote_sampled_bit i=%0d got=%b exp=%b", i, sbit, exp_sbit); else n_pass++;
            if (i == vpos) begin
                n_total++;
                if (svalid !== 1'b1 || sbit !== 1'b1 || ecnt !== 6'(vpos - 16))
                    $display("FAIL vote_point valid=%b bit=%b edge_cnt=%0d exp valid=1 bit=1 edge_cnt=%0d", svalid, sbit, ecnt, vpos - 16);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] plist [8] = '{6'd8, 6'd16, 6'd32, 6'd20, 6'd0, 6'd63, 6'd8, 6'd16};
        int         hold = 0;
        bit         line = 1'b1;
        bit         e    = 1'b0;
        bit         drv;
        logic [5:0] p    = 6'd8;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                line = 1'($urandom_range(0, 1));
                hold = $urandom_range(3, 40);
            end else hold--;
            if (e && $urandom_range(0, 199) == 0) e = 1'b0;
            else if (!e && $urandom_range(0, 9) == 0) e = 1'b1;
            if ($urandom_range(0, 63) == 0) p = plist[$urandom_range(0, 7)];
            drv = line ^ ($urandom_range(0, 29) == 0);
            cycle(drv, e, p);
            n_total++; if (ecnt   !== 6'(exp_cnt)) $display("FAIL rnd_edge_cnt cyc=%0d got=%0d exp=%0d", cyc, ecnt, exp_cnt); else n_pass++;
            n_total++; if (bdone  !== exp_done)    $display("FAIL rnd_bit_done cyc=%0d got=%b exp=%b", cyc, bdone, exp_done); else n_pass++;
            n_total++; if (svalid !== exp_valid)   $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, svalid, exp_valid); else n_pass++;
            n_total++; if (sbit   !== exp_sbit)    $display("FAIL rnd_sampled_bit cyc=%0d got=%b exp=%b", cyc, sbit, exp_sbit); else n_pass++;
            n_total++; if (rsync  !== exp_sync)    $display("FAIL rnd_rx_sync cyc=%0d got=%b exp=%b", cyc, rsync, exp_sync); else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 6'd16);
        for (int i = 0; i < 21; i++) begin
            cycle(1'b0, 1'b1, 6'd16);
            n_total++; if (sbit !== exp_sbit) $display("FAIL areset_pre_bit i=%0d got=%b exp=%b", i, sbit, exp_sbit); else n_pass++;
        end
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (sbit   !== 1'b1) $display("FAIL areset_sampled_bit got=%b exp=1", sbit);   else n_pass++;
        n_total++; if (svalid !== 1'b0) $display("FAIL areset_samp_valid got=%b exp=0", svalid); else n_pass++;
        n_total++; if (ecnt   !== 6'd0) $display("FAIL areset_edge_cnt got=%0d exp=0", ecnt);   else n_pass++;
        n_total++; if (bdone  !== 1'b0) $display("FAIL areset_bit_done got=%b exp=0", bdone);   else n_pass++;
        n_total++; if (rsync  !== 1'b1) $display("FAIL areset_rx_sync got=%b exp=1", rsync);    else n_pass++;
        release_reset();
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, (i >= 2), 6'd8);
            n_total++; if (ecnt !== 6'(exp_cnt)) $display("FAIL areset_post_cnt i=%0d got=%0d exp=%0d", i, ecnt, exp_cnt); else n_pass++;
            n_total++; if (sbit !== exp_sbit)    $display("FAIL areset_post_bit i=%0d got=%b exp=%b", i, sbit, exp_sbit); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_p8_basic();
        test_glitch();
        test_disable();
        test_prescale();
        test_vote_pattern();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached passed=%0d total=%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
